audio_adc_rx: RTL and testbench
===============================

// Module: audio_adc_rx
// PURPOSE
//  I2S capture path for the codec ADC; the receive counterpart of the audio DAC serializer.
//  Sits beside AUDIO_DAC and samples AUD_ADCDAT using the BCK/LRCK the FPGA already drives.
//  Deserializes each stereo frame in the iCLK domain and presents it to the fabric on a
//  one-deep valid/ready register, with a sticky overrun flag.
// PARAMETERS
//  DATA_WIDTH   16  bits kept per channel, MSB-first, two's complement
//  SYNC_STAGES  2   flip-flop synchronizer depth on BCK/LRCK/ADCDAT (>=2)
// PORTS
//  iCLK         in   1           system clock, >= 4x BCK frequency
//  iRST_N       in   1           async active-low reset
//  iAUD_BCK     in   1           I2S bit clock (async to iCLK)
//  iAUD_LRCK    in   1           ADC word clock; 0 = left, 1 = right
//  iAUD_ADCDAT  in   1           serial ADC data
//  oLEFT        out  DATA_WIDTH  left sample of the held frame
//  oRIGHT       out  DATA_WIDTH  right sample of the held frame
//  oVALID       out  1           held frame valid
//  iREADY       in   1           consumer accepts the frame when oVALID && iREADY
//  oOVERRUN     out  1           sticky: a completed frame overwrote an unaccepted frame
//  iOVR_CLR     in   1           synchronous clear of oOVERRUN
// BEHAVIOUR
//  - Reset (async, iRST_N=0): all outputs 0; FSM=IDLE; shift/holding registers 0.
//  - BCK, LRCK and ADCDAT pass through identical SYNC_STAGES chains, so they stay mutually aligned.
//  - Edge detect on the synchronized signals. A BCK rise is the sample strobe. An LRCK change is the
//    channel boundary.
//  - FSM:
//      IDLE  -> SKIP on the first LRCK fall (start of left channel). Partial frames are discarded.
//      SKIP  -> SHIFT on the next BCK rise. I2S one-bit delay: that bit is not captured.
//      SHIFT: on each BCK rise, shift ADCDAT in MSB-first and count bits.
//             At count==DATA_WIDTH -> HOLD.
//      HOLD: extra bits are ignored (truncation).
//  - On any LRCK edge seen in SKIP/SHIFT/HOLD:
//      - Latch the shift register into the channel just ended. If fewer than DATA_WIDTH bits were
//        captured, the value is left-justified and the LSBs are zero-padded.
//      - Clear the bit count and go to SKIP.
//  - Frame complete = LRCK fall after a right channel that began after leaving IDLE.
//    On completion, oLEFT/oRIGHT/oVALID=1 are loaded in the next iCLK. Latency is
//    SYNC_STAGES+2 iCLK cycles from the raw LRCK fall.
//  - Handshake: oVALID clears the cycle after oVALID && iREADY, unless a frame completes in the
//    same cycle. In that case the new frame is loaded, oVALID stays 1, and there is no overrun.
//  - Completion while oVALID=1 && iREADY=0: the new frame overwrites the held one and oOVERRUN is
//    set to 1. If set and iOVR_CLR land in the same cycle, set wins.
//  - oLEFT/oRIGHT are stable while oVALID=1 && iREADY=0, unless an overrun overwrites them.
//  - Reset mid-frame: the partial frame is discarded. After reset, the first output is the first
//    complete L+R pair starting at an LRCK fall.
//  - An LRCK edge with no BCK rise since the last boundary latches 0 for that channel.
// CONFIGURATION
//  AUDIO_ADC_PEAK_EN defined:
//  - Adds ports oPEAK_L/oPEAK_R (out, DATA_WIDTH, unsigned) and iPEAK_CLR (in, 1).
//  - On each frame load, each peak register updates to max(peak, |sample|).
//    |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1) is held unsigned.
//  - iPEAK_CLR zeroes both peaks. If a clear and a load land in the same cycle, the peak takes
//    |sample|. Peaks reset to 0.
//  AUDIO_ADC_PEAK_EN undefined: these ports and the peak logic are absent. All other behaviour is
//  identical.
// TESTING (codec model: BCK = iCLK/8, 32 BCK per channel, DATA_WIDTH=16)
//  1. L=16'hA5C3, R=16'h5A3C, iREADY=1
//     -> oVALID 1-cycle pulse with oLEFT=A5C3, oRIGHT=5A3C, SYNC_STAGES+2 cycles after the LRCK fall.
//  2. iREADY=0 for frames (1111,2222) then (3333,4444)
//     -> oOVERRUN=1, outputs 3333/4444.
//     -> iOVR_CLR pulse gives oOVERRUN=0.
//  3. Assert iRST_N=0 during the 5th left bit, then release
//     -> outputs 0, and the first oVALID carries the next full frame only.
//  4. 12 BCK per channel, L=12'hABC
//     -> oLEFT=16'hABC0. With 24 BCK per channel, L=24'h123456 -> oLEFT=16'h1234.
//  5. Frame completes in the same cycle iREADY accepts the previous frame
//     -> oVALID stays 1, new data is loaded, oOVERRUN=0.
//  6. (AUDIO_ADC_PEAK_EN) L=-32768 then L=1000
//     -> oPEAK_L=16'h8000 held. iPEAK_CLR then L=1000 -> oPEAK_L=1000.

Source files
------------

// File: rtl/audio_adc_rx.sv
// I2S receiver for the codec ADC: synchronizes BCK/LRCK/ADCDAT, deserializes stereo frames,
// and holds them on a one-deep valid/ready register. Define AUDIO_ADC_PEAK_EN for peak meters.
module audio_adc_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_LRCK,
    input  logic                  iAUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] oLEFT,
    output logic [DATA_WIDTH-1:0] oRIGHT,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oOVERRUN,
    input  logic                  iOVR_CLR
`ifdef AUDIO_ADC_PEAK_EN
    ,
    output logic [DATA_WIDTH-1:0] oPEAK_L,
    output logic [DATA_WIDTH-1:0] oPEAK_R,
    input  logic                  iPEAK_CLR
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

    logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, dat_sync;
    logic                   bck_prev, lrck_prev;
    logic                   bck_s, lrck_s, dat_s;
    logic                   bck_rise, lrck_edge, lrck_fall;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  justified;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  left_lat, right_lat;
    logic                   in_right;
    logic                   frame_done;

    // Identical chains keep the three I2S lines aligned with each other.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bck_prev  <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bck_sync  <= {bck_sync[SYNC_STAGES-2:0], iAUD_BCK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], iAUD_LRCK};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], iAUD_ADCDAT};
            bck_prev  <= bck_sync[SYNC_STAGES-1];
            lrck_prev <= lrck_sync[SYNC_STAGES-1];
        end
    end

    assign bck_s     = bck_sync[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign bck_rise  = bck_s & ~bck_prev;
    assign lrck_edge = lrck_s ^ lrck_prev;
    assign lrck_fall = lrck_edge & ~lrck_s;

    // Short words end up left-justified; an empty channel shifts out to zero.
    always_comb begin
        justified = shift_reg << (DATA_WIDTH - int'(bit_cnt));
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            left_lat   <= '0;
            right_lat  <= '0;
            in_right   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (lrck_fall) begin
                    state     <= SKIP;
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    in_right  <= 1'b0;
                end
            end else if (lrck_edge) begin
                if (lrck_prev)
                    right_lat <= justified;
                else
                    left_lat  <= justified;
                frame_done <= lrck_fall & in_right;
                in_right   <= lrck_s;
                shift_reg  <= '0;
                bit_cnt    <= '0;
                state      <= SKIP;
            end else if (bck_rise) begin
                case (state)
                    SKIP:  state <= SHIFT;
                    SHIFT: begin
                        shift_reg <= {shift_reg[DATA_WIDTH-2:0], dat_s};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1))
                            state <= HOLD;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A completing frame always loads; it only counts as an overrun if the held one was not taken.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oLEFT    <= '0;
            oRIGHT   <= '0;
            oVALID   <= 1'b0;
            oOVERRUN <= 1'b0;
        end else begin
            if (frame_done) begin
                oLEFT  <= left_lat;
                oRIGHT <= right_lat;
                oVALID <= 1'b1;
            end else if (oVALID && iREADY) begin
                oVALID <= 1'b0;
            end
            if (frame_done && oVALID && !iREADY)
                oOVERRUN <= 1'b1;
            else if (iOVR_CLR)
                oOVERRUN <= 1'b0;
        end
    end

`ifdef AUDIO_ADC_PEAK_EN
    function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] s);
        return s[DATA_WIDTH-1] ? (~s + DATA_WIDTH'(1)) : s;
    endfunction

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oPEAK_L <= '0;
            oPEAK_R <= '0;
        end else if (frame_done) begin
            if (iPEAK_CLR || mag(left_lat) > oPEAK_L)
                oPEAK_L <= mag(left_lat);
            if (iPEAK_CLR || mag(right_lat) > oPEAK_R)
                oPEAK_R <= mag(right_lat);
        end else if (iPEAK_CLR) begin
            oPEAK_L <= '0;
            oPEAK_R <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Self-checking bench for audio_adc_rx: drives an I2S codec model (BCK = iCLK/8) and checks
// captured frames against expectations derived from the driven bit stream.
module tb_audio_adc_rx;

    localparam int W    = 16;
    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iAUD_BCK = 1'b0;
    logic          iAUD_LRCK = 1'b1;
    logic          iAUD_ADCDAT = 1'b0;
    logic [W-1:0]  oLEFT, oRIGHT;
    logic          oVALID;
    logic          iREADY = 1'b0;
    logic          oOVERRUN;
    logic          iOVR_CLR = 1'b0;
`ifdef AUDIO_ADC_PEAK_EN
    logic [W-1:0]  oPEAK_L, oPEAK_R;
    logic          iPEAK_CLR = 1'b0;
`endif

    audio_adc_rx #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iAUD_BCK    (iAUD_BCK),
        .iAUD_LRCK   (iAUD_LRCK),
        .iAUD_ADCDAT (iAUD_ADCDAT),
        .oLEFT       (oLEFT),
        .oRIGHT      (oRIGHT),
        .oVALID      (oVALID),
        .iREADY      (iREADY),
        .oOVERRUN    (oOVERRUN),
        .iOVR_CLR    (iOVR_CLR)
`ifdef AUDIO_ADC_PEAK_EN
        ,
        .oPEAK_L     (oPEAK_L),
        .oPEAK_R     (oPEAK_R),
        .iPEAK_CLR   (iPEAK_CLR)
`endif
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          last_fall_cyc = 0;
    int          rise_lat = -1;
    int          run_len = 0;
    int          max_run = 0;
    bit          auto_ready = 1'b0;
    logic        prev_valid = 1'b0;

    function automatic int mag(input logic [W-1:0] s);
        int v;
        v = int'($signed(s));
        return (v < 0) ? -v : v;
    endfunction

    // One iCLK step; also observes the handshake and records accepted frames.
    task automatic tick();
        @(negedge iCLK);
        if (auto_ready)
            iREADY = (cyc == last_fall_cyc + SYNC + 1);
        if (oVALID && iREADY)
            got_q.push_back({oLEFT, oRIGHT});
        if (oVALID && !prev_valid)
            rise_lat = cyc - last_fall_cyc;
        run_len = oVALID ? run_len + 1 : 0;
        if (run_len > max_run)
            max_run = run_len;
        prev_valid = oVALID;
    endtask

    // One channel of nbck BCK periods: a delay bit, then word MSB-first, then random filler.
    // The expected value is the first W data bits after the delay bit, left-justified.
    task automatic drive_channel(input bit lr, input logic [31:0] word, input int dw,
                                 input int nbck, input int rst_bit, output logic [W-1:0] expv);
        logic [W-1:0] e;
        logic         bitv;
        e = '0;
        if (nbck == 0) begin
            iAUD_BCK = 1'b0;
            if (!lr && iAUD_LRCK) last_fall_cyc = cyc;
            iAUD_LRCK = lr;
            repeat (2 * HALF) tick();
        end
        for (int b = 0; b < nbck; b++) begin
            if (b >= 1 && b - 1 < dw)
                bitv = word[dw - b];
            else
                bitv = 1'($urandom);
            if (b >= 1 && b - 1 < W)
                e[W - b] = bitv;
            iAUD_BCK = 1'b0;
            if (b == 0) begin
                if (!lr && iAUD_LRCK) last_fall_cyc = cyc;
                iAUD_LRCK = lr;
            end
            iAUD_ADCDAT = bitv;
            if (b == rst_bit) iRST_N = 1'b0;
            repeat (HALF) tick();
            iRST_N = 1'b1;
            iAUD_BCK = 1'b1;
            repeat (HALF) tick();
        end
        expv = e;
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int dwl,
                              input int dwr, input int nbl, input int nbr);
        logic [W-1:0] el, er;
        drive_channel(1'b0, l, dwl, nbl, -1, el);
        drive_channel(1'b1, r, dwr, nbr, -1, er);
        exp_q.push_back({el, er});
    endtask

    task automatic send_tail();
        logic [W-1:0] dummy;
        drive_channel(1'b0, 32'd0, 0, 4, -1, dummy);
        repeat (8) tick();
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        iAUD_LRCK = 1'b1;
        iAUD_BCK = 1'b0;
        iAUD_ADCDAT = 1'b0;
        iOVR_CLR = 1'b0;
`ifdef AUDIO_ADC_PEAK_EN
        iPEAK_CLR = 1'b0;
`endif
        repeat (3) tick();
        iRST_N = 1'b1;
        repeat (4) tick();
        got_q.delete();
        exp_q.delete();
        run_len = 0;
        max_run = 0;
        rise_lat = -1;
    endtask

    task automatic test_reset();
        do_reset();
        iREADY = 1'b0;
        send_frame($urandom | 32'h8001, $urandom | 32'h8001, 16, 16, 32, 32);
        send_tail();
        #2 iRST_N = 1'b0;
        #1;
        tests_run++;
        if (oVALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b want 0", oVALID); end
        tests_run++;
        if (oLEFT !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_left: got %h want 0000", oLEFT); end
        tests_run++;
        if (oRIGHT !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_right: got %h want 0000", oRIGHT); end
        tests_run++;
        if (oOVERRUN !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b want 0", oOVERRUN); end
`ifdef AUDIO_ADC_PEAK_EN
        tests_run++;
        if (oPEAK_L !== 16'h0 || oPEAK_R !== 16'h0) begin
            tests_failed++; $display("[TB] FAIL reset_peak: got %h/%h want 0000/0000", oPEAK_L, oPEAK_R);
        end
`endif
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        iREADY = 1'b1;
        send_frame(32'hA5C3, 32'h5A3C, 16, 16, 32, 32);
        send_tail();
        tests_run++;
        if (got_q.size() !== 1) begin tests_failed++; $display("[TB] FAIL basic_count: got %0d want 1", got_q.size()); end
        else begin
            tests_run++;
            if (got_q[0] !== 32'hA5C3_5A3C) begin
                tests_failed++; $display("[TB] FAIL basic_data: got %h want a5c35a3c", got_q[0]);
            end
        end
        tests_run++;
        if (rise_lat !== SYNC + 2) begin tests_failed++; $display("[TB] FAIL basic_latency: got %0d want %0d", rise_lat, SYNC + 2); end
        tests_run++;
        if (max_run !== 1) begin tests_failed++; $display("[TB] FAIL basic_pulse: got %0d cycles want 1", max_run); end
    endtask

    task automatic test_random();
        do_reset();
        iREADY = 1'b1;
        for (int i = 0; i < 6; i++)
            send_frame($urandom, $urandom, 16, 16, $urandom_range(2, 34), $urandom_range(2, 34));
        send_tail();
        tests_run++;
        if (got_q.size() !== exp_q.size()) begin
            tests_failed++; $display("[TB] FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (got_q[i] !== exp_q[i]) begin
                    tests_failed++; $display("[TB] FAIL random_frame%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        iREADY = 1'b0;
        send_frame(32'h1111, 32'h2222, 16, 16, 32, 32);
        send_frame(32'h3333, 32'h4444, 16, 16, 32, 32);
        send_tail();
        tests_run++;
        if (oOVERRUN !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_flag: got %b want 1", oOVERRUN); end
        tests_run++;
        if ({oLEFT, oRIGHT} !== 32'h3333_4444) begin
            tests_failed++; $display("[TB] FAIL ovr_data: got %h%h want 33334444", oLEFT, oRIGHT);
        end
        tests_run++;
        if (oVALID !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_valid: got %b want 1", oVALID); end
        iOVR_CLR = 1'b1;
        tick();
        iOVR_CLR = 1'b0;
        tick();
        tests_run++;
        if (oOVERRUN !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_clear: got %b want 0", oOVERRUN); end
        tests_run++;
        if (oLEFT !== 16'h3333) begin tests_failed++; $display("[TB] FAIL ovr_hold: got %h want 3333", oLEFT); end
        iREADY = 1'b1;
        tick();
        tick();
        tests_run++;
        if (oVALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_accept: got %b want 0", oVALID); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] dummy;
        do_reset();
        iREADY = 1'b0;
        send_frame($urandom | 32'h1, $urandom | 32'h1, 16, 16, 32, 32);
        drive_channel(1'b0, $urandom, 16, 32, 5, dummy);
        tests_run++;
        if ({oVALID, oLEFT, oRIGHT} !== 33'h0) begin
            tests_failed++; $display("[TB] FAIL midrst_clear: got v=%b %h/%h want 0", oVALID, oLEFT, oRIGHT);
        end
        exp_q.delete();
        got_q.delete();
        iREADY = 1'b1;
        drive_channel(1'b1, $urandom, 16, 32, -1, dummy);
        send_frame($urandom, $urandom, 16, 16, 32, 32);
        send_tail();
        tests_run++;
        if (got_q.size() !== 1) begin tests_failed++; $display("[TB] FAIL midrst_count: got %0d want 1", got_q.size()); end
        else begin
            tests_run++;
            if (got_q[0] !== exp_q[0]) begin
                tests_failed++; $display("[TB] FAIL midrst_data: got %h want %h", got_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_truncate();
        logic [31:0] f;
        do_reset();
        iREADY = 1'b1;
        send_frame(32'hABC, $urandom, 12, 12, 12, 12);
        send_frame(32'h123456, $urandom, 24, 24, 24, 24);
        send_frame($urandom, $urandom, 16, 16, 1, 0);
        send_tail();
        tests_run++;
        if (got_q.size() !== 3) begin tests_failed++; $display("[TB] FAIL trunc_count: got %0d want 3", got_q.size()); end
        else begin
            f = got_q[0];
            tests_run++;
            if (f[31:16] !== 16'hABC0) begin tests_failed++; $display("[TB] FAIL trunc_short: got %h want abc0", f[31:16]); end
            f = got_q[1];
            tests_run++;
            if (f[31:16] !== 16'h1234) begin tests_failed++; $display("[TB] FAIL trunc_long: got %h want 1234", f[31:16]); end
            f = got_q[2];
            tests_run++;
            if (f !== 32'h0) begin tests_failed++; $display("[TB] FAIL trunc_empty: got %h want 00000000", f); end
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (got_q[i] !== exp_q[i]) begin
                    tests_failed++; $display("[TB] FAIL trunc_frame%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        iREADY = 1'b0;
        auto_ready = 1'b1;
        send_frame($urandom, $urandom, 16, 16, 32, 32);
        send_frame($urandom, $urandom, 16, 16, 32, 32);
        send_tail();
        auto_ready = 1'b0;
        iREADY = 1'b0;
        tick();
        tests_run++;
        if (oVALID !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid: got %b want 1", oVALID); end
        tests_run++;
        if ({oLEFT, oRIGHT} !== exp_q[1]) begin
            tests_failed++; $display("[TB] FAIL b2b_data: got %h%h want %h", oLEFT, oRIGHT, exp_q[1]);
        end
        tests_run++;
        if (oOVERRUN !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_overrun: got %b want 0", oOVERRUN); end
        tests_run++;
        if (got_q.size() !== 1) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d want 1", got_q.size()); end
        else begin
            tests_run++;
            if (got_q[0] !== exp_q[0]) begin
                tests_failed++; $display("[TB] FAIL b2b_first: got %h want %h", got_q[0], exp_q[0]);
            end
        end
    endtask

`ifdef AUDIO_ADC_PEAK_EN
    task automatic test_peak();
        logic [W-1:0] r1, r2, r3, e;
        int           m;
        do_reset();
        iREADY = 1'b1;
        r1 = W'($urandom);
        r2 = W'($urandom);
        r3 = W'($urandom);
        send_frame(32'h8000, {16'd0, r1}, 16, 16, 32, 32);
        send_frame(32'd1000, {16'd0, r2}, 16, 16, 32, 32);
        send_tail();
        tests_run++;
        if (oPEAK_L !== 16'h8000) begin tests_failed++; $display("[TB] FAIL peak_l_max: got %h want 8000", oPEAK_L); end
        m = (mag(r1) > mag(r2)) ? mag(r1) : mag(r2);
        e = W'(m);
        tests_run++;
        if (oPEAK_R !== e) begin tests_failed++; $display("[TB] FAIL peak_r_max: got %h want %h", oPEAK_R, e); end
        iPEAK_CLR = 1'b1;
        tick();
        iPEAK_CLR = 1'b0;
        tick();
        tests_run++;
        if (oPEAK_L !== 16'h0 || oPEAK_R !== 16'h0) begin
            tests_failed++; $display("[TB] FAIL peak_clear: got %h/%h want 0000/0000", oPEAK_L, oPEAK_R);
        end
        send_frame(32'd1000, {16'd0, r3}, 16, 16, 32, 32);
        send_tail();
        tests_run++;
        if (oPEAK_L !== 16'd1000) begin tests_failed++; $display("[TB] FAIL peak_l_new: got %h want %h", oPEAK_L, 16'd1000); end
        e = W'(mag(r3));
        tests_run++;
        if (oPEAK_R !== e) begin tests_failed++; $display("[TB] FAIL peak_r_new: got %h want %h", oPEAK_R, e); end
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_basic();
        test_random();
        test_overrun();
        test_reset_mid();
        test_truncate();
        test_back_to_back();
`ifdef AUDIO_ADC_PEAK_EN
        test_peak();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
